// File: rtl/pool_pkg.sv
// Shared widths, counts and state encoding for the pool_1 max-pooling stage.
package pool_pkg;
    localparam int DW       = 16;
    localparam int ROW_PIX  = 28;
    localparam int CH_PAIRS = 3;

    localparam int OUT_PIX  = ROW_PIX / 2;           // 14 pooled pixels per row
    localparam int CH_IN_W  = ROW_PIX * DW;          // 448 bits per channel in
    localparam int CH_OUT_W = OUT_PIX * DW;          // 224 bits per channel out
    localparam int FM1_W    = 2 * CH_IN_W;           // 896
    localparam int FM2_W    = 2 * CH_OUT_W;          // 448
    localparam int N_OUT    = CH_PAIRS * OUT_PIX;    // 42 writes per pass
    localparam int RD_AW    = 7;
    localparam int WR_AW    = 6;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/pool_1_if.sv
// Read side of fm_bram_1 (dual port, same cycle) and write side of fm_bram_2.
interface pool_1_if;
    import pool_pkg::*;

    logic               fm1_en;
    logic [RD_AW-1:0]   fm1_addra;
    logic [RD_AW-1:0]   fm1_addrb;
    logic [FM1_W-1:0]   fm1_douta;
    logic [FM1_W-1:0]   fm1_doutb;
    logic               fm2_we;
    logic [WR_AW-1:0]   fm2_addr;
    logic [FM2_W-1:0]   fm2_din;

    modport master (
        output fm1_en, fm1_addra, fm1_addrb,
        input  fm1_douta, fm1_doutb,
        output fm2_we, fm2_addr, fm2_din
    );

    modport slave (
        input  fm1_en, fm1_addra, fm1_addrb,
        output fm1_douta, fm1_doutb,
        input  fm2_we, fm2_addr, fm2_din
    );
endinterface

// File: rtl/pool_1_max4_relu.sv
// Combinational signed max of a 2x2 window, optionally clamping negatives to 0.
module max4_relu
    import pool_pkg::*;
#(
    parameter int W       = DW,
    parameter bit RELU_EN = 1'b1
) (
    input  logic signed [W-1:0] a0_i,
    input  logic signed [W-1:0] a1_i,
    input  logic signed [W-1:0] b0_i,
    input  logic signed [W-1:0] b1_i,
    output logic signed [W-1:0] y_o
);
    logic signed [W-1:0] max_a;
    logic signed [W-1:0] max_b;
    logic signed [W-1:0] max_all;

    always_comb begin
        max_a   = (a0_i > a1_i) ? a0_i : a1_i;
        max_b   = (b0_i > b1_i) ? b0_i : b1_i;
        max_all = (max_a > max_b) ? max_a : max_b;
        y_o     = (RELU_EN && max_all[W-1]) ? '0 : max_all;
    end
endmodule

// File: rtl/pool_1.sv
// 2x2/stride-2 max-pool: streams 42 row-pair reads from fm_bram_1 and writes
// one pooled word per cycle into fm_bram_2, RD_LAT+1 cycles after each read.
module pool_1
    import pool_pkg::*;
#(
    parameter int RD_LAT  = 2,
    parameter bit RELU_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      pool_1_en,
    pool_1_if.master  bus,
    output logic      busy,
    output logic      pool_1_finish
);
    localparam logic [RD_AW-1:0] LAST_BASE = RD_AW'((CH_PAIRS - 1) * ROW_PIX);
    localparam logic [3:0]       LAST_COL  = 4'(OUT_PIX - 1);

    state_e             state_q, state_d;
    logic               en_q;
    logic [3:0]         col_q;
    logic [RD_AW-1:0]   row_base_q;
    logic [WR_AW-1:0]   wr_cnt_q;
    logic [WR_AW-1:0]   wr_addr_q;
    logic [RD_LAT:0]    vld_q;
    logic [FM2_W-1:0]   din_q;
    logic [FM2_W-1:0]   pooled;
    logic               start, abort, last_rd, rd_en;
    logic [RD_AW-1:0]   rd_addr;

    assign start   = pool_1_en & ~en_q;
    assign abort   = ~pool_1_en & ((state_q == RUN) | (state_q == DRAIN));
    assign rd_en   = (state_q == RUN);
    assign last_rd = (row_base_q == LAST_BASE) && (col_q == LAST_COL);
    assign rd_addr = row_base_q + {2'b00, col_q, 1'b0};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (abort) state_d = IDLE;
                     else if (last_rd) state_d = DRAIN;
            // The final write is in flight once nothing is left behind it.
            DRAIN:   if (abort) state_d = IDLE;
                     else if (~|vld_q[RD_LAT-1:0]) state_d = DONE;
            DONE:    if (!pool_1_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            col_q      <= '0;
            row_base_q <= '0;
            wr_cnt_q   <= '0;
            wr_addr_q  <= '0;
            vld_q      <= '0;
            din_q      <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= pool_1_en;

            if ((state_q == IDLE) && start) begin
                col_q      <= '0;
                row_base_q <= '0;
                wr_cnt_q   <= '0;
            end else if (rd_en) begin
                if (col_q == LAST_COL) begin
                    col_q      <= '0;
                    row_base_q <= row_base_q + RD_AW'(ROW_PIX);
                end else begin
                    col_q <= col_q + 4'd1;
                end
            end

            // Abort flushes reads still in flight so they never turn into writes.
            if (abort) vld_q <= '0;
            else       vld_q <= {vld_q[RD_LAT-1:0], rd_en};

            if (vld_q[RD_LAT-1] && !abort) begin
                din_q     <= pooled;
                wr_addr_q <= wr_cnt_q;
                wr_cnt_q  <= wr_cnt_q + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        for (genvar gj = 0; gj < OUT_PIX; gj++) begin : g_px
            max4_relu #(.W(DW), .RELU_EN(RELU_EN)) u_max (
                .a0_i (bus.fm1_douta[gi*CH_IN_W + (2*gj)*DW   +: DW]),
                .a1_i (bus.fm1_douta[gi*CH_IN_W + (2*gj+1)*DW +: DW]),
                .b0_i (bus.fm1_doutb[gi*CH_IN_W + (2*gj)*DW   +: DW]),
                .b1_i (bus.fm1_doutb[gi*CH_IN_W + (2*gj+1)*DW +: DW]),
                .y_o  (pooled[gi*CH_OUT_W + gj*DW +: DW])
            );
        end
    end

    assign bus.fm1_en    = rd_en;
    assign bus.fm1_addra = rd_en ? rd_addr : '0;
    assign bus.fm1_addrb = rd_en ? rd_addr + 1'b1 : '0;
    assign bus.fm2_we    = vld_q[RD_LAT];
    assign bus.fm2_addr  = wr_addr_q;
    assign bus.fm2_din   = din_q;
    assign busy          = (state_q == RUN) | (state_q == DRAIN);
    assign pool_1_finish = (state_q == DONE);
endmodule

// File: tb/tb_pool_1.sv
// Directed bench for pool_1: ramp passes, window maths, timing, abort, reset, re-arm.
module tb_pool_1;
    import pool_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic busy;
    logic fin;
    int   errors = 0;
    int   checks = 0;

    pool_1_if bus ();

    pool_1 #(.RD_LAT(2), .RELU_EN(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .pool_1_en     (en),
        .bus           (bus.master),
        .busy          (busy),
        .pool_1_finish (fin)
    );

    // Stand-alone window with clamping disabled.
    logic signed [DW-1:0] ta0, ta1, tb0, tb1, ty;
    max4_relu #(.W(DW), .RELU_EN(1'b0)) u_ref (
        .a0_i (ta0), .a1_i (ta1), .b0_i (tb0), .b1_i (tb1), .y_o (ty)
    );

    always #5 clk = ~clk;

    // fm_bram_1 model: two register stages from address to dout.
    logic [FM1_W-1:0] mem [0:127];
    logic [FM1_W-1:0] sa, sb;
    always @(posedge clk) begin
        if (bus.fm1_en) begin
            sa <= mem[bus.fm1_addra];
            sb <= mem[bus.fm1_addrb];
        end
        bus.fm1_douta <= sa;
        bus.fm1_doutb <= sb;
    end

    // Write log.
    int               wr_n;
    logic [WR_AW-1:0] wr_a  [0:63];
    logic [FM2_W-1:0] wr_d  [0:63];
    logic [FM2_W-1:0] pass1 [0:63];
    always @(negedge clk) begin
        if (bus.fm2_we === 1'b1 && wr_n < 64) begin
            wr_a[wr_n] = bus.fm2_addr;
            wr_d[wr_n] = bus.fm2_din;
            $display("write #%0d addr=%0d pix0=%0d", wr_n, bus.fm2_addr, $signed(bus.fm2_din[DW-1:0]));
            wr_n++;
        end
    end

    function automatic logic [FM1_W-1:0] in_word(int v);
        logic [FM1_W-1:0] w;
        for (int j = 0; j < 2 * ROW_PIX; j++) w[j*DW +: DW] = DW'(v);
        return w;
    endfunction

    function automatic logic [FM2_W-1:0] out_word(int v);
        logic [FM2_W-1:0] w;
        for (int j = 0; j < 2 * OUT_PIX; j++) w[j*DW +: DW] = DW'(v);
        return w;
    endfunction

    function automatic int exp_addra(int k);
        return (k / 14) * 28 + 2 * (k % 14);
    endfunction

    task automatic ramp_mem();
        for (int i = 0; i < 128; i++) mem[i] = in_word(i);
    endtask

    // Raise en, let the pass finish, drop en again.
    task automatic run_pass();
        wr_n = 0;
        @(negedge clk); en = 1'b1;
        repeat (50) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wr_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.fm1_en !== 1'b0) begin errors++; $display("FAIL reset fm1_en got %b want 0", bus.fm1_en); end
        checks++; if (bus.fm1_addra !== 7'd0 || bus.fm1_addrb !== 7'd0) begin errors++; $display("FAIL reset rd_addr got %0d/%0d want 0/0", bus.fm1_addra, bus.fm1_addrb); end
        checks++; if (bus.fm2_we !== 1'b0 || bus.fm2_addr !== 6'd0) begin errors++; $display("FAIL reset wr got we=%b addr=%0d want 0", bus.fm2_we, bus.fm2_addr); end
        checks++; if (bus.fm2_din !== '0) begin errors++; $display("FAIL reset fm2_din got %h want 0", bus.fm2_din); end
        checks++; if (busy !== 1'b0 || fin !== 1'b0) begin errors++; $display("FAIL reset status got busy=%b fin=%b want 0/0", busy, fin); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timing();
        int k;
        ramp_mem();
        wr_n = 0;
        en = 1'b1;                       // cycle 0
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            checks++;
            if (bus.fm1_en !== ((c >= 1 && c <= 42) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL timing fm1_en cycle %0d got %b", c, bus.fm1_en);
            end
            if (c <= 42) begin
                k = c - 1;
                checks++;
                if (bus.fm1_addra !== 7'(exp_addra(k)) || bus.fm1_addrb !== 7'(exp_addra(k) + 1)) begin
                    errors++; $display("FAIL timing rd_addr k=%0d got %0d/%0d want %0d/%0d", k, bus.fm1_addra, bus.fm1_addrb, exp_addra(k), exp_addra(k) + 1);
                end
            end
            checks++;
            if (bus.fm2_we !== ((c >= 4 && c <= 45) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL timing fm2_we cycle %0d got %b", c, bus.fm2_we);
            end
            if (c >= 4 && c <= 45) begin
                k = c - 4;
                checks++;
                if (bus.fm2_addr !== 6'(k) || bus.fm2_din !== out_word(exp_addra(k) + 1)) begin
                    errors++; $display("FAIL timing write k=%0d got addr=%0d pix0=%0d want addr=%0d pix=%0d", k, bus.fm2_addr, bus.fm2_din[DW-1:0], k, exp_addra(k) + 1);
                end
            end
            checks++;
            if (fin !== ((c >= 46) ? 1'b1 : 1'b0) || busy !== ((c <= 45) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL timing status cycle %0d got fin=%b busy=%b", c, fin, busy);
            end
        end
        // k=15 reads rows 30/31, so every pooled pixel is 31.
        checks++;
        if (wr_n != 42 || wr_d[15] !== out_word(31)) begin
            errors++; $display("FAIL pass1 k15 got writes=%0d pix0=%0d want 42/31", wr_n, wr_d[15][DW-1:0]);
        end
        for (int i = 0; i < 64; i++) pass1[i] = wr_d[i];
    endtask

    task automatic test_ignored_edge();
        // en has stayed high since the pass started; DONE must hold.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (fin !== 1'b1 || bus.fm1_en !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL ignored_edge hold got fin=%b fm1_en=%b busy=%b want 1/0/0", fin, bus.fm1_en, busy);
            end
        end
        checks++; if (wr_n != 42) begin errors++; $display("FAIL ignored_edge writes got %0d want 42", wr_n); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (fin !== 1'b0) begin errors++; $display("FAIL ignored_edge fin_fall got %b want 0", fin); end
        run_pass();
        checks++; if (wr_n != 42) begin errors++; $display("FAIL second_pass count got %0d want 42", wr_n); end
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (wr_a[i] !== 6'(i) || wr_d[i] !== pass1[i]) begin
                errors++; $display("FAIL second_pass k=%0d got addr=%0d pix0=%0d want addr=%0d pix0=%0d", i, wr_a[i], wr_d[i][DW-1:0], i, pass1[i][DW-1:0]);
            end
        end
    endtask

    task automatic test_single_window();
        logic [FM2_W-1:0] exp_w;
        ramp_mem();
        mem[0][0 +: DW]            = 16'sd5;
        mem[0][DW +: DW]           = -16'sd3;
        mem[1][0 +: DW]            = 16'sd9;
        mem[1][DW +: DW]           = 16'sd7;
        mem[0][CH_IN_W +: DW]      = -16'sd2;
        mem[0][CH_IN_W + DW +: DW] = -16'sd8;
        mem[1][CH_IN_W +: DW]      = -16'sd1;
        mem[1][CH_IN_W + DW +: DW] = -16'sd4;
        exp_w = out_word(1);
        exp_w[0 +: DW]        = 16'd9;
        exp_w[CH_OUT_W +: DW] = 16'd0;
        run_pass();
        checks++; if (wr_n != 42) begin errors++; $display("FAIL window count got %0d want 42", wr_n); end
        checks++; if (wr_d[0][0 +: DW] !== 16'sd9) begin errors++; $display("FAIL window max got %0d want 9", $signed(wr_d[0][0 +: DW])); end
        checks++; if (wr_d[0][CH_OUT_W +: DW] !== 16'sd0) begin errors++; $display("FAIL window relu got %0d want 0", $signed(wr_d[0][CH_OUT_W +: DW])); end
        checks++; if (wr_d[0] !== exp_w) begin errors++; $display("FAIL window word got %h want %h", wr_d[0], exp_w); end
        ta0 = -16'sd2; ta1 = -16'sd8; tb0 = -16'sd1; tb1 = -16'sd4;
        #1;
        checks++; if (ty !== -16'sd1) begin errors++; $display("FAIL window no_relu got %0d want -1", ty); end
        ta0 = 16'sd5; ta1 = -16'sd3; tb0 = 16'sd9; tb1 = 16'sd7;
        #1;
        checks++; if (ty !== 16'sd9) begin errors++; $display("FAIL window no_relu_pos got %0d want 9", ty); end
    endtask

    task automatic test_abort();
        ramp_mem();
        wr_n = 0;
        @(negedge clk); en = 1'b1;       // cycle 0
        for (int c = 1; c <= 11; c++) @(negedge clk);
        checks++; if (bus.fm1_addra !== 7'd20) begin errors++; $display("FAIL abort k10 addra got %0d want 20", bus.fm1_addra); end
        en = 1'b0;                       // dropped while k=10 is being read
        for (int c = 12; c <= 30; c++) begin
            @(negedge clk);
            checks++;
            if ((c >= 13 && bus.fm2_we !== 1'b0) || busy !== 1'b0 || bus.fm1_en !== 1'b0) begin
                errors++; $display("FAIL abort quiet cycle %0d got we=%b busy=%b fm1_en=%b want 0/0/0", c, bus.fm2_we, busy, bus.fm1_en);
            end
        end
        checks++; if (wr_n > 9) begin errors++; $display("FAIL abort count got %0d want <=9", wr_n); end
        for (int i = 0; i < wr_n; i++) begin
            checks++;
            if (wr_a[i] > 6'd12) begin errors++; $display("FAIL abort addr got %0d want <=12", wr_a[i]); end
        end
        run_pass();
        checks++; if (wr_n != 42) begin errors++; $display("FAIL abort rerun count got %0d want 42", wr_n); end
        for (int i = 0; i < 42; i++) begin
            checks++;
            if (wr_a[i] !== 6'(i) || wr_d[i] !== pass1[i]) begin
                errors++; $display("FAIL abort rerun k=%0d got addr=%0d pix0=%0d", i, wr_a[i], wr_d[i][DW-1:0]);
            end
        end
    endtask

    task automatic test_reset_drain();
        ramp_mem();
        wr_n = 0;
        @(negedge clk); en = 1'b1;       // cycle 0
        for (int c = 1; c <= 43; c++) @(negedge clk);
        checks++; if (busy !== 1'b1 || bus.fm1_en !== 1'b0) begin errors++; $display("FAIL rst_drain pre got busy=%b fm1_en=%b want 1/0", busy, bus.fm1_en); end
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.fm2_we !== 1'b0 || bus.fm2_addr !== 6'd0 || bus.fm2_din !== '0 || busy !== 1'b0 || fin !== 1'b0 || bus.fm1_en !== 1'b0) begin
            errors++; $display("FAIL rst_drain outputs got we=%b addr=%0d busy=%b fin=%b want all 0", bus.fm2_we, bus.fm2_addr, busy, fin);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.fm2_we !== 1'b0 || fin !== 1'b0) begin errors++; $display("FAIL rst_drain quiet got we=%b fin=%b want 0/0", bus.fm2_we, fin); end
        end
        checks++; if (wr_n != 40) begin errors++; $display("FAIL rst_drain count got %0d want 40", wr_n); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_ignored_edge();
        test_single_window();
        test_abort();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
